// File: rtl/apb_reg_bank.sv
// rtl/apb_reg_bank.sv - APB slave register bank with byte strobes, RO masking, wait states and hw update port
module apb_reg_bank #(
  parameter int                           DATA_W      = 32,
  parameter int                           NUM_REGS    = 8,
  parameter int                           WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]          RO_MASK     = '0,
  parameter logic [NUM_REGS*DATA_W-1:0]   RESET_VALS  = '0
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic [31:0]                    paddr,
  input  logic [DATA_W-1:0]              pwdata,
  input  logic [DATA_W/8-1:0]            pstrb,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  output logic [DATA_W-1:0]              prdata,
  output logic                           pready,
  output logic                           pslverr,
  input  logic [NUM_REGS-1:0]            hw_wr,
  input  logic [NUM_REGS*DATA_W-1:0]     hw_wdata,
  output logic [NUM_REGS*DATA_W-1:0]     reg_q
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(NUM_REGS);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [DATA_W-1:0]    regs_d [NUM_REGS];

  logic                 addr_ok;
  logic [IDX_W-1:0]     idx;
  logic                 ro_hit;
  logic [DATA_W-1:0]    rd_word;
  logic                 wr_ok;

  // Only word-aligned addresses inside the bank decode to a register.
  assign addr_ok = (paddr[1:0] == 2'b00) && (paddr < 32'(4 * NUM_REGS));
  assign idx     = paddr[IDX_W+1:2];

  // Select the addressed register's contents and read-only attribute.
  always_comb begin
    ro_hit  = 1'b0;
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (IDX_W'(i) == idx) begin
        ro_hit  = RO_MASK[i];
        rd_word = regs_q[i];
      end
    end
  end

  // Response is purely a function of registered state and the live bus.
  assign pready  = (state_q == ACCESS) && (cnt_q == 4'd0) && psel && penable;
  assign wr_ok   = pready && pwrite && addr_ok && !ro_hit;
  assign pslverr = pready && (!addr_ok || (pwrite && ro_hit));
  assign prdata  = (pready && !pwrite && addr_ok) ? rd_word : '0;

  // Transfer sequencing: SETUP moves to ACCESS, wait counter burns down, completion or abort returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (penable) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Next register values: hw port loads whole word, APB strobed bytes override on a shared target.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = hw_wr[i] ? hw_wdata[i*DATA_W +: DATA_W] : regs_q[i];
      if (wr_ok && (IDX_W'(i) == idx)) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (pstrb[b]) begin
            regs_d[i][8*b +: 8] = pwdata[8*b +: 8];
          end
        end
      end
    end
  end

  // State, counter and register storage with asynchronous reset to the programmed values.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALS[i*DATA_W +: DATA_W];
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: tb/tb_apb_reg_bank.sv
// tb/tb_apb_reg_bank.sv - directed self-checking bench for apb_reg_bank
module tb_apb_reg_bank;

  localparam logic [255:0] RST_VALS = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                       32'h1234_9876, 32'h5A5A_5555, 32'h0};

  logic         pclk = 1'b0;
  logic         preset0, preset1;
  logic [31:0]  paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic         psel0, psel1, penable, pwrite;
  logic [31:0]  prdata0, prdata1;
  logic         pready0, pready1, pslverr0, pslverr1;
  logic [7:0]   hw_wr0, hw_wr1;
  logic [255:0] hw_wdata0, hw_wdata1;
  logic [255:0] reg_q0, reg_q1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 pclk = ~pclk;

  apb_reg_bank #(
    .DATA_W(32), .NUM_REGS(8), .WAIT_STATES(0), .RO_MASK(8'h02), .RESET_VALS(RST_VALS)
  ) u_dut (
    .pclk(pclk), .preset(preset0), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .psel(psel0), .penable(penable), .pwrite(pwrite), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .hw_wr(hw_wr0), .hw_wdata(hw_wdata0), .reg_q(reg_q0)
  );

  apb_reg_bank #(
    .DATA_W(32), .NUM_REGS(8), .WAIT_STATES(3), .RO_MASK(8'h00), .RESET_VALS(RST_VALS)
  ) u_dut_ws (
    .pclk(pclk), .preset(preset1), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .psel(psel1), .penable(penable), .pwrite(pwrite), .prdata(prdata1), .pready(pready1),
    .pslverr(pslverr1), .hw_wr(hw_wr1), .hw_wdata(hw_wdata1), .reg_q(reg_q1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One APB transfer on instance inst (0 = no waits, 1 = three waits); reports data, error and wait count.
  task automatic apb_xfer(input int inst, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic err, output int waits);
    logic done;
    done  = 1'b0;
    waits = 0;
    rdata = '0;
    err   = 1'b0;
    @(posedge pclk); #1;
    paddr = addr; pwdata = data; pstrb = strb; pwrite = wr; penable = 1'b0;
    if (inst == 0) psel0 = 1'b1; else psel1 = 1'b1;
    @(posedge pclk); #1;
    penable = 1'b1;
    while (!done && waits < 20) begin
      @(negedge pclk);
      if ((inst == 0) ? pready0 : pready1) begin
        rdata = (inst == 0) ? prdata0 : prdata1;
        err   = (inst == 0) ? pslverr0 : pslverr1;
        done  = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!done) chk("xfer_timeout", 32'(done), 32'd1);
    @(posedge pclk); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          wt;

  initial begin
    preset0 = 1'b1; preset1 = 1'b1;
    paddr = '0; pwdata = '0; pstrb = '0; psel0 = 1'b0; psel1 = 1'b0;
    penable = 1'b0; pwrite = 1'b0;
    hw_wr0 = '0; hw_wr1 = '0; hw_wdata0 = '0; hw_wdata1 = '0;
    repeat (2) @(posedge pclk);
    #1 preset0 = 1'b0; preset1 = 1'b0;

    // Reset state
    @(negedge pclk);
    chk("rst_pready", 32'(pready0), 32'd0);
    chk("rst_prdata", prdata0, 32'h0);
    chk("rst_pslverr", 32'(pslverr0), 32'd0);
    chk("rst_reg1", reg_q0[32 +: 32], 32'h5A5A_5555);
    chk("rst_reg2", reg_q0[64 +: 32], 32'h1234_9876);

    // 1: disturb reg2, pulse reset mid-run, read back reset values
    apb_xfer(0, 1'b1, 32'h08, 32'hCAFE_F00D, 4'hF, rd, er, wt);
    chk("pre_rst_reg2", reg_q0[64 +: 32], 32'hCAFE_F00D);
    @(posedge pclk); #2 preset0 = 1'b1; #3 preset0 = 1'b0;
    apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, wt);
    chk("t1_rd04", rd, 32'h5A5A_5555);
    chk("t1_err04", 32'(er), 32'd0);
    chk("t1_wait04", 32'(wt), 32'd0);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, rd, er, wt);
    chk("t1_rd08", rd, 32'h1234_9876);
    chk("t1_err08", 32'(er), 32'd0);

    // 2: strobed write of low half
    apb_xfer(0, 1'b1, 32'h08, 32'hDEAD_BEEF, 4'b0011, rd, er, wt);
    chk("t2_werr", 32'(er), 32'd0);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, rd, er, wt);
    chk("t2_rd08", rd, 32'h1234_BEEF);
    chk("t2_regq2", reg_q0[64 +: 32], 32'h1234_BEEF);

    // 3: read-only register rejects APB write, accepts hw port
    apb_xfer(0, 1'b1, 32'h04, 32'hFFFF_FFFF, 4'hF, rd, er, wt);
    chk("t3_ro_err", 32'(er), 32'd1);
    apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, wt);
    chk("t3_ro_rd", rd, 32'h5A5A_5555);
    chk("t3_ro_rderr", 32'(er), 32'd0);
    @(posedge pclk); #1;
    hw_wr0 = 8'h02; hw_wdata0[32 +: 32] = 32'h0000_00AA;
    @(posedge pclk); #1;
    hw_wr0 = 8'h00;
    apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, wt);
    chk("t3_hw_rd", rd, 32'h0000_00AA);

    // 4: illegal addresses and empty-strobe write
    apb_xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, wt);
    chk("t4_rd20_err", 32'(er), 32'd1);
    chk("t4_rd20_data", rd, 32'h0);
    apb_xfer(0, 1'b0, 32'h06, 32'h0, 4'h0, rd, er, wt);
    chk("t4_rd06_err", 32'(er), 32'd1);
    chk("t4_rd06_data", rd, 32'h0);
    apb_xfer(0, 1'b1, 32'h24, 32'hFFFF_FFFF, 4'hF, rd, er, wt);
    chk("t4_wr24_err", 32'(er), 32'd1);
    apb_xfer(0, 1'b1, 32'h0A, 32'hFFFF_FFFF, 4'hF, rd, er, wt);
    chk("t4_wr0a_err", 32'(er), 32'd1);
    apb_xfer(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, rd, er, wt);
    chk("t4_nostrb_err", 32'(er), 32'd0);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e;
      e = (i == 1) ? 32'h0000_00AA : (i == 2) ? 32'h1234_BEEF : 32'h0;
      chk($sformatf("t4_reg%0d", i), reg_q0[i*32 +: 32], e);
    end

    // Last register in the bank is reachable
    apb_xfer(0, 1'b1, 32'h1C, 32'h89AB_CDEF, 4'hF, rd, er, wt);
    chk("last_werr", 32'(er), 32'd0);
    apb_xfer(0, 1'b0, 32'h1C, 32'h0, 4'h0, rd, er, wt);
    chk("last_rd", rd, 32'h89AB_CDEF);

    // 5: wait states, then reset during the second wait cycle of a write
    apb_xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, rd, er, wt);
    chk("t5_waits", 32'(wt), 32'd3);
    chk("t5_rd08", rd, 32'h1234_9876);
    chk("t5_err", 32'(er), 32'd0);
    @(posedge pclk); #1;
    paddr = 32'h08; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF; pwrite = 1'b1;
    psel1 = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    chk("t5_w1_pready", 32'(pready1), 32'd0);
    @(posedge pclk); #1;
    preset1 = 1'b1;
    #2 chk("t5_rst_pready", 32'(pready1), 32'd0);
    #2 preset1 = 1'b0;
    repeat (2) @(posedge pclk);
    #1 psel1 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk("t5_reg2_kept", reg_q1[64 +: 32], 32'h1234_9876);

    // 6: simultaneous APB and hw writes on reg3, independent hw write on reg4
    @(posedge pclk); #1;
    paddr = 32'h0C; pwdata = 32'h1111_1111; pstrb = 4'b1100; pwrite = 1'b1;
    psel0 = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    hw_wr0 = 8'h18;
    hw_wdata0[96 +: 32]  = 32'h2222_2222;
    hw_wdata0[128 +: 32] = 32'h3333_3333;
    @(negedge pclk);
    chk("t6_pready", 32'(pready0), 32'd1);
    chk("t6_err", 32'(pslverr0), 32'd0);
    @(posedge pclk); #1;
    psel0 = 1'b0; penable = 1'b0; hw_wr0 = 8'h00;
    @(negedge pclk);
    chk("t6_reg3", reg_q0[96 +: 32], 32'h1111_2222);
    chk("t6_reg4", reg_q0[128 +: 32], 32'h3333_3333);
    chk("t6_idle_prdata", prdata0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
